// File: rtl/md5_cand_pkg.sv
// Shared types and constants for the MD5 candidate counter generator.
package md5_cand_pkg;

  localparam int CAND_WIDTH          = 32;
  localparam int DEFAULT_HIT_LATENCY = 66;
  localparam int HIT_CNT_MAX         = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/candidate_counter_gen_tail_tracker.sv
// Follows which candidate is at the pipeline tail: tail equals the value issued
// HIT_LATENCY cycles earlier once the pipeline has filled (tail_valid).
module candidate_tail_tracker
  import md5_cand_pkg::*;
#(
  parameter int WIDTH       = CAND_WIDTH,
  parameter int HIT_LATENCY = DEFAULT_HIT_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_pulse,
  input  logic [WIDTH-1:0] start_value,
  input  logic             issue,
  output logic [WIDTH-1:0] tail,
  output logic             tail_valid
);

  localparam logic [7:0] LAT = 8'(HIT_LATENCY);

  logic [7:0]       lag_q, lag_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  // The first issue starts the lag count; it then keeps counting every cycle,
  // so a short run still fills the pipeline model before the tail is trusted.
  always_comb begin
    lag_d  = lag_q;
    tail_d = tail_q;
    if (start_pulse) begin
      lag_d  = 8'd0;
      tail_d = start_value;
    end else if (lag_q == LAT) begin
      tail_d = tail_q + WIDTH'(1);
    end else if (issue || (lag_q != 8'd0)) begin
      lag_d = lag_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lag_q  <= 8'd0;
      tail_q <= '0;
    end else begin
      lag_q  <= lag_d;
      tail_q <= tail_d;
    end
  end

  assign tail       = tail_q;
  assign tail_valid = (lag_q == LAT);

endmodule

// File: rtl/candidate_counter_gen.sv
// Issues one candidate per clock over [start_value, end_value] with wrap-around
// and captures hits at the pipeline tail. Optional macro: CANDGEN_PERF_CNT_EN.
module candidate_counter_gen
  import md5_cand_pkg::*;
#(
  parameter int WIDTH       = CAND_WIDTH,
  parameter int HIT_LATENCY = DEFAULT_HIT_LATENCY
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] start_value,
  input  logic [WIDTH-1:0] end_value,
  input  logic             start,
  input  logic             stop,
  input  logic             hit,
  output logic [WIDTH-1:0] counter_out,
  output logic             counter_valid,
  output logic             busy,
  output logic             done,
  output logic             found_valid,
  output logic [WIDTH-1:0] found_value,
`ifdef CANDGEN_PERF_CNT_EN
  output logic [7:0]       hit_count,
  output logic [31:0]      run_cycles
`else
  output logic [7:0]       hit_count
`endif
);

  localparam logic [7:0] LAT     = 8'(HIT_LATENCY);
  localparam logic [7:0] HIT_MAX = 8'(HIT_CNT_MAX);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [7:0]       drain_q, drain_d;
  logic             found_valid_q, found_valid_d;
  logic [WIDTH-1:0] found_value_q, found_value_d;
  logic [7:0]       hit_count_q, hit_count_d;
`ifdef CANDGEN_PERF_CNT_EN
  logic [31:0]      run_cycles_q, run_cycles_d;
`endif

  logic             start_accept;
  logic             hit_ok;
  logic [WIDTH-1:0] tail;
  logic             tail_valid;

  assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign hit_ok       = hit && tail_valid && ((state_q == RUN) || (state_q == DRAIN));

  candidate_tail_tracker #(
    .WIDTH      (WIDTH),
    .HIT_LATENCY(HIT_LATENCY)
  ) u_tail (
    .clk        (CLK),
    .rst_n      (RST_N),
    .start_pulse(start_accept),
    .start_value(start_value),
    .issue      (valid_q),
    .tail       (tail),
    .tail_valid (tail_valid)
  );

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    valid_d       = valid_q;
    end_d         = end_q;
    drain_d       = drain_q;
    found_valid_d = found_valid_q;
    found_value_d = found_value_q;
    hit_count_d   = hit_count_q;
`ifdef CANDGEN_PERF_CNT_EN
    run_cycles_d  = run_cycles_q;
    if (valid_q && (run_cycles_q != 32'hFFFF_FFFF)) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          counter_d     = start_value;
          valid_d       = 1'b1;
          end_d         = end_value;
          found_valid_d = 1'b0;
          found_value_d = '0;
          hit_count_d   = 8'd0;
`ifdef CANDGEN_PERF_CNT_EN
          run_cycles_d  = 32'd0;
`endif
          state_d       = RUN;
        end
      end
      RUN: begin
        // Leaving on a match means the end value was already shown for a cycle.
        if (stop || (counter_q == end_q)) begin
          valid_d = 1'b0;
          drain_d = LAT;
          state_d = DRAIN;
        end else begin
          counter_d = counter_q + WIDTH'(1);
        end
      end
      DRAIN: begin
        drain_d = drain_q - 8'd1;
        if (drain_q <= 8'd1) begin
          drain_d = 8'd0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hit_ok) begin
      if (hit_count_q != HIT_MAX) begin
        hit_count_d = hit_count_q + 8'd1;
      end
      if (!found_valid_q) begin
        found_valid_d = 1'b1;
        found_value_d = tail;
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      end_q         <= '0;
      drain_q       <= 8'd0;
      found_valid_q <= 1'b0;
      found_value_q <= '0;
      hit_count_q   <= 8'd0;
`ifdef CANDGEN_PERF_CNT_EN
      run_cycles_q  <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      end_q         <= end_d;
      drain_q       <= drain_d;
      found_valid_q <= found_valid_d;
      found_value_q <= found_value_d;
      hit_count_q   <= hit_count_d;
`ifdef CANDGEN_PERF_CNT_EN
      run_cycles_q  <= run_cycles_d;
`endif
    end
  end

  assign counter_out   = counter_q;
  assign counter_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign found_valid   = found_valid_q;
  assign found_value   = found_value_q;
  assign hit_count     = hit_count_q;
`ifdef CANDGEN_PERF_CNT_EN
  assign run_cycles    = run_cycles_q;
`endif

endmodule
